// File: rtl/gb_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gb_mem_pkg
// Description : Shared types and address constants for the Game Boy memory
//               responder: region decode, serial FSM encoding, IO addresses.
// Revision    : 1.0  initial release
// ============================================================================
package gb_mem_pkg;

    typedef enum logic [2:0] {
        REGION_ROM      = 3'd0,
        REGION_UNMAPPED = 3'd1,
        REGION_WRAM     = 3'd2,
        REGION_IO       = 3'd3,
        REGION_HRAM     = 3'd4,
        REGION_IE       = 3'd5
    } region_t;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_SHIFT = 2'd1,
        SER_DONE  = 2'd2
    } ser_state_t;

    localparam logic [15:0] c_addr_sb  = 16'hFF01;
    localparam logic [15:0] c_addr_sc  = 16'hFF02;
    localparam logic [15:0] c_addr_div = 16'hFF04;
    localparam logic [15:0] c_addr_if  = 16'hFF0F;
    localparam logic [15:0] c_addr_ie  = 16'hFFFF;

    function automatic region_t decode_region(input logic [15:0] addr);
        region_t r;
        if (addr[15] == 1'b0)       r = REGION_ROM;
        else if (addr < 16'hC000)   r = REGION_UNMAPPED;
        else if (addr < 16'hFE00)   r = REGION_WRAM;      // includes the E000 echo
        else if (addr < 16'hFF00)   r = REGION_UNMAPPED;
        else if (addr < 16'hFF80)   r = REGION_IO;
        else if (addr == c_addr_ie) r = REGION_IE;
        else                        r = REGION_HRAM;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gb_serial_port.sv
`default_nettype none
// ============================================================================
// Module      : gb_serial_port
// Description : SB/SC serial port with a fixed-length transfer timer; emits
//               each completed byte on a one-clock strobe and requests IF[3].
// Revision    : 1.0  initial release
// ============================================================================
module gb_serial_port
    import gb_mem_pkg::*;
#(
    parameter int XFER_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_wr_sb,
    input  logic       i_wr_sc,
    input  logic [7:0] i_wr_data,
    output logic [7:0] o_sb,
    output logic [7:0] o_sc,
    output logic [7:0] o_serial_byte,
    output logic       o_serial_valid,
    output logic       o_if_set
);

    localparam int CNT_W = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(XFER_CYCLES - 1);

    ser_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_sb;
    logic             r_sc7;
    logic             r_sc0;
    logic [7:0]       r_byte;
    logic             r_valid;

    // CPU writes are locked out only while shifting; in DONE they land after completion.
    logic w_accept;
    logic w_start;
    assign w_accept = (r_state != SER_SHIFT);
    assign w_start  = w_accept && i_wr_sc && i_wr_data[7] && i_wr_data[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SER_IDLE;
            r_cnt   <= '0;
            r_sb    <= 8'h00;
            r_sc7   <= 1'b0;
            r_sc0   <= 1'b0;
            r_byte  <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                SER_IDLE: begin
                    if (w_start) begin
                        r_state <= SER_SHIFT;
                        r_cnt   <= c_cnt_load;
                    end
                end
                SER_SHIFT: begin
                    if (r_cnt == '0) r_state <= SER_DONE;
                    else             r_cnt   <= r_cnt - CNT_W'(1);
                end
                SER_DONE: begin
                    r_byte  <= r_sb;
                    r_valid <= 1'b1;
                    r_sb    <= 8'hFF;
                    r_sc7   <= 1'b0;
                    if (w_start) begin
                        r_state <= SER_SHIFT;
                        r_cnt   <= c_cnt_load;
                    end else begin
                        r_state <= SER_IDLE;
                    end
                end
                default: r_state <= SER_IDLE;
            endcase
            // Placed last so a write in the DONE clock overrides the completion values.
            if (w_accept && i_wr_sb) r_sb <= i_wr_data;
            if (w_accept && i_wr_sc) begin
                r_sc7 <= i_wr_data[7];
                r_sc0 <= i_wr_data[0];
            end
        end
    end

    assign o_sb           = r_sb;
    assign o_sc           = {r_sc7, 6'b111111, r_sc0};
    assign o_serial_byte  = r_byte;
    assign o_serial_valid = r_valid;
    assign o_if_set       = (r_state == SER_DONE);

endmodule
`default_nettype wire

// File: rtl/gb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : gb_mem_responder
// Description : CPU memory-bus responder: ROM forwarding, WRAM/HRAM, DIV,
//               serial, IF and IE, with a fixed one-clock read latency.
// Revision    : 1.0  initial release
// ============================================================================
module gb_mem_responder
    import gb_mem_pkg::*;
#(
    parameter int WRAM_AW     = 13,
    parameter int XFER_CYCLES = 8,
    parameter int DIV_SHIFT   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] mem_addr,
    input  logic [7:0]  mem_data_write,
    input  logic        mem_do_write,
    output logic [7:0]  mem_data_read,
    output logic [14:0] ext_addr,
    input  logic [7:0]  ext_rd_data,
    output logic        ext_wr_en,
    output logic [7:0]  ext_wr_data,
    output logic [7:0]  serial_byte,
    output logic        serial_valid,
    output logic [4:0]  irq_if
);

    localparam int WRAM_DEPTH = 1 << WRAM_AW;
    localparam int HRAM_DEPTH = 127;

    logic [7:0] r_wram [WRAM_DEPTH];
    logic [7:0] r_hram [HRAM_DEPTH];

    region_t     w_region;
    region_t     r_rd_region;
    logic [7:0]  r_rd_byte;
    logic [15:0] r_div;
    logic [4:0]  r_if;
    logic [7:0]  r_ie;

    logic [WRAM_AW-1:0] w_wram_idx;
    logic [6:0]         w_hram_idx;
    logic [7:0]         w_rd_next;
    logic [7:0]         w_sb;
    logic [7:0]         w_sc;
    logic               w_if_set;
    logic               w_wr_sb;
    logic               w_wr_sc;
    logic               w_wr_div;
    logic               w_wr_if;
    logic               w_wr_ie;

    assign w_region   = decode_region(mem_addr);
    assign w_wram_idx = mem_addr[WRAM_AW-1:0];
    assign w_hram_idx = mem_addr[6:0];

    assign w_wr_sb  = mem_do_write && (mem_addr == c_addr_sb);
    assign w_wr_sc  = mem_do_write && (mem_addr == c_addr_sc);
    assign w_wr_div = mem_do_write && (mem_addr == c_addr_div);
    assign w_wr_if  = mem_do_write && (mem_addr == c_addr_if);
    assign w_wr_ie  = mem_do_write && (mem_addr == c_addr_ie);

    assign ext_addr    = mem_addr[14:0];
    assign ext_wr_en   = mem_do_write && (w_region == REGION_ROM);
    assign ext_wr_data = mem_data_write;

    gb_serial_port #(
        .XFER_CYCLES (XFER_CYCLES)
    ) u_serial (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_wr_sb        (w_wr_sb),
        .i_wr_sc        (w_wr_sc),
        .i_wr_data      (mem_data_write),
        .o_sb           (w_sb),
        .o_sc           (w_sc),
        .o_serial_byte  (serial_byte),
        .o_serial_valid (serial_valid),
        .o_if_set       (w_if_set)
    );

    // Read mux sees pre-edge state, which gives read-first behaviour on collisions.
    always_comb begin
        w_rd_next = 8'hFF;
        case (w_region)
            REGION_WRAM: w_rd_next = r_wram[w_wram_idx];
            REGION_HRAM: w_rd_next = r_hram[w_hram_idx];
            REGION_IE:   w_rd_next = r_ie;
            REGION_IO: begin
                case (mem_addr)
                    c_addr_sb:  w_rd_next = w_sb;
                    c_addr_sc:  w_rd_next = w_sc;
                    c_addr_div: w_rd_next = r_div[DIV_SHIFT+7:DIV_SHIFT];
                    c_addr_if:  w_rd_next = {3'b111, r_if};
                    default:    w_rd_next = 8'hFF;
                endcase
            end
            default:     w_rd_next = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_do_write && (w_region == REGION_WRAM)) r_wram[w_wram_idx] <= mem_data_write;
        if (mem_do_write && (w_region == REGION_HRAM)) r_hram[w_hram_idx] <= mem_data_write;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_region <= REGION_UNMAPPED;
            r_rd_byte   <= 8'hFF;
            r_div       <= 16'h0000;
            r_if        <= 5'h00;
            r_ie        <= 8'h00;
        end else begin
            r_rd_region <= w_region;
            r_rd_byte   <= w_rd_next;
            r_div       <= w_wr_div ? 16'h0000 : (r_div + 16'h0001);
            // Serial completion ORs IF[3] on top of a same-clock CPU write.
            r_if        <= (w_wr_if ? mem_data_write[4:0] : r_if) | (w_if_set ? 5'b01000 : 5'b00000);
            if (w_wr_ie) r_ie <= mem_data_write;
        end
    end

    assign mem_data_read = (r_rd_region == REGION_ROM) ? ext_rd_data : r_rd_byte;
    assign irq_if        = r_if;

endmodule
`default_nettype wire

// File: tb/tb_gb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_gb_mem_responder
// Description : Directed vector table plus hand sequences for serial timing,
//               DIV and asynchronous reset of gb_mem_responder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gb_mem_responder;

    localparam int WRAM_AW     = 13;
    localparam int XFER_CYCLES = 8;
    localparam int DIV_SHIFT   = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] mem_addr = 16'h0000;
    logic [7:0]  mem_data_write = 8'h00;
    logic        mem_do_write = 1'b0;
    logic [7:0]  mem_data_read;
    logic [14:0] ext_addr;
    logic [7:0]  ext_rd_data = 8'h00;
    logic        ext_wr_en;
    logic [7:0]  ext_wr_data;
    logic [7:0]  serial_byte;
    logic        serial_valid;
    logic [4:0]  irq_if;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gb_mem_responder #(
        .WRAM_AW     (WRAM_AW),
        .XFER_CYCLES (XFER_CYCLES),
        .DIV_SHIFT   (DIV_SHIFT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_addr       (mem_addr),
        .mem_data_write (mem_data_write),
        .mem_do_write   (mem_do_write),
        .mem_data_read  (mem_data_read),
        .ext_addr       (ext_addr),
        .ext_rd_data    (ext_rd_data),
        .ext_wr_en      (ext_wr_en),
        .ext_wr_data    (ext_wr_data),
        .serial_byte    (serial_byte),
        .serial_valid   (serial_valid),
        .irq_if         (irq_if)
    );

    function automatic logic [7:0] rom_byte(input logic [14:0] a);
        return (a == 15'h0100) ? 8'h3C : (a[7:0] ^ 8'hA5);
    endfunction

    // Synchronous ROM model: data valid one clock after the address.
    always @(posedge clk) ext_rd_data <= rom_byte(ext_addr);

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        we;
        logic        chk;
        logic [7:0]  exp;
        logic        exp_wen;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [15:0] a, input logic [7:0] d, input logic we,
                                input logic c, input logic [7:0] e, input logic wen, input string n);
        vec_t v;
        v.addr = a; v.wdata = d; v.we = we; v.chk = c; v.exp = e; v.exp_wen = wen; v.name = n;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic we);
        mem_addr = a; mem_data_write = d; mem_do_write = we;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e, input string n);
        cyc(a, 8'h00, 1'b0);
        chk(n, mem_data_read, e);
    endtask

    int         p_cnt;
    int         p_first;
    int         p_second;
    logic [7:0] p_byte1;
    logic [7:0] p_byte2;

    // Load SB, start a transfer, then watch ncyc clocks with up to two injected writes.
    task automatic xfer(input logic [7:0] sbv,
                        input int wk1, input logic [15:0] wa1, input logic [7:0] wd1,
                        input int wk2, input logic [15:0] wa2, input logic [7:0] wd2,
                        input int ncyc);
        cyc(16'hFF01, sbv, 1'b1);
        cyc(16'hFF02, 8'h81, 1'b1);
        p_cnt = 0; p_first = -1; p_second = -1; p_byte1 = 8'h00; p_byte2 = 8'h00;
        for (int k = 1; k <= ncyc; k++) begin
            if (k == wk1)      begin mem_addr = wa1; mem_data_write = wd1; mem_do_write = 1'b1; end
            else if (k == wk2) begin mem_addr = wa2; mem_data_write = wd2; mem_do_write = 1'b1; end
            else               begin mem_addr = 16'h0000; mem_data_write = 8'h00; mem_do_write = 1'b0; end
            @(posedge clk);
            @(negedge clk);
            if (serial_valid) begin
                p_cnt++;
                if (p_cnt == 1)      begin p_first = k;  p_byte1 = serial_byte; end
                else if (p_cnt == 2) begin p_second = k; p_byte2 = serial_byte; end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_pulses;

        // Reset state
        @(negedge clk);
        chk("rst_read", mem_data_read, 8'hFF);
        chk("rst_if", irq_if, 5'h00);
        chk("rst_valid", serial_valid, 1'b0);
        chk("rst_byte", serial_byte, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        vecs.push_back(mk(16'hFF02, 8'h00, 0, 1, 8'h7E, 0, "sc_reset"));
        vecs.push_back(mk(16'hFF02, 8'h80, 1, 0, 8'h00, 0, "sc_w80"));
        vecs.push_back(mk(16'hFF02, 8'h00, 0, 1, 8'hFE, 0, "sc_80_read"));
        vecs.push_back(mk(16'hFF02, 8'h00, 1, 0, 8'h00, 0, "sc_clear"));
        vecs.push_back(mk(16'hC123, 8'h5A, 1, 0, 8'h00, 0, "wram_w"));
        vecs.push_back(mk(16'hE123, 8'h00, 0, 1, 8'h5A, 0, "wram_echo"));
        vecs.push_back(mk(16'hFF90, 8'hA5, 1, 0, 8'h00, 0, "hram_w"));
        vecs.push_back(mk(16'hFF90, 8'h00, 0, 1, 8'hA5, 0, "hram_r"));
        vecs.push_back(mk(16'hFF80, 8'h11, 1, 0, 8'h00, 0, "hram_lo_w"));
        vecs.push_back(mk(16'hFFFE, 8'hEE, 1, 0, 8'h00, 0, "hram_hi_w"));
        vecs.push_back(mk(16'hFF80, 8'h00, 0, 1, 8'h11, 0, "hram_lo_r"));
        vecs.push_back(mk(16'hFFFE, 8'h00, 0, 1, 8'hEE, 0, "hram_hi_r"));
        vecs.push_back(mk(16'h0100, 8'h00, 0, 1, 8'h3C, 0, "rom_0100"));
        vecs.push_back(mk(16'hC000, 8'h42, 1, 0, 8'h00, 0, "wram_c000_w"));
        vecs.push_back(mk(16'h2000, 8'h01, 1, 1, 8'hA5, 1, "mbc_write"));
        vecs.push_back(mk(16'hC000, 8'h00, 0, 1, 8'h42, 0, "wram_c000_r"));
        vecs.push_back(mk(16'h9000, 8'h00, 0, 1, 8'hFF, 0, "unmap_9000"));
        vecs.push_back(mk(16'h9000, 8'h12, 1, 1, 8'hFF, 0, "unmap_9000_w"));
        vecs.push_back(mk(16'h9000, 8'h00, 0, 1, 8'hFF, 0, "unmap_9000_r"));
        vecs.push_back(mk(16'hFE10, 8'h33, 1, 1, 8'hFF, 0, "unmap_fe10_w"));
        vecs.push_back(mk(16'hFE10, 8'h00, 0, 1, 8'hFF, 0, "unmap_fe10_r"));
        vecs.push_back(mk(16'hFF50, 8'h12, 1, 1, 8'hFF, 0, "io_unl_w"));
        vecs.push_back(mk(16'hFF50, 8'h00, 0, 1, 8'hFF, 0, "io_unl_r"));
        vecs.push_back(mk(16'hFFFF, 8'h1F, 1, 1, 8'h00, 0, "ie_w_oldval"));
        vecs.push_back(mk(16'hFFFF, 8'h00, 0, 1, 8'h1F, 0, "ie_r"));
        vecs.push_back(mk(16'hC200, 8'h77, 1, 0, 8'h00, 0, "rdw_w1"));
        vecs.push_back(mk(16'hC200, 8'h88, 1, 1, 8'h77, 0, "rdw_readfirst"));
        vecs.push_back(mk(16'hC200, 8'h00, 0, 1, 8'h88, 0, "rdw_r"));
        vecs.push_back(mk(16'hC300, 8'h99, 1, 0, 8'h00, 0, "hold_w1"));
        vecs.push_back(mk(16'hC300, 8'h99, 1, 1, 8'h99, 0, "hold_w2"));
        vecs.push_back(mk(16'hC300, 8'h00, 0, 1, 8'h99, 0, "hold_r"));
        vecs.push_back(mk(16'hFF0F, 8'h05, 1, 1, 8'hE0, 0, "if_w_oldval"));
        vecs.push_back(mk(16'hFF0F, 8'h00, 0, 1, 8'hE5, 0, "if_r"));
        vecs.push_back(mk(16'hFF0F, 8'h00, 1, 1, 8'hE5, 0, "if_clr"));
        vecs.push_back(mk(16'hFF0F, 8'h00, 0, 1, 8'hE0, 0, "if_r0"));
        vecs.push_back(mk(16'hFF01, 8'h00, 0, 1, 8'h00, 0, "sb_untouched"));
        vecs.push_back(mk(16'h0000, 8'h00, 0, 1, 8'hA5, 0, "rom_0000"));

        foreach (vecs[i]) begin
            mem_addr = vecs[i].addr; mem_data_write = vecs[i].wdata; mem_do_write = vecs[i].we;
            #1;
            chk({vecs[i].name, "_wen"}, ext_wr_en, vecs[i].exp_wen);
            @(posedge clk);
            @(negedge clk);
            if (vecs[i].chk) chk(vecs[i].name, mem_data_read, vecs[i].exp);
        end

        // Basic transfer
        xfer(8'h48, 0, 16'h0000, 8'h00, 0, 16'h0000, 8'h00, 14);
        chk("xfer_pulses", p_cnt, 1);
        chk("xfer_time", p_first, XFER_CYCLES + 1);
        chk("xfer_byte", p_byte1, 8'h48);
        rd(16'hFF01, 8'hFF, "xfer_sb");
        rd(16'hFF02, 8'h7F, "xfer_sc");
        rd(16'hFF0F, 8'hE8, "xfer_if");

        // Retrigger and SB write during SHIFT are ignored
        cyc(16'hFF0F, 8'h00, 1'b1);
        xfer(8'hC3, 3, 16'hFF02, 8'h81, 4, 16'hFF01, 8'h00, 14);
        chk("retrig_pulses", p_cnt, 1);
        chk("retrig_time", p_first, XFER_CYCLES + 1);
        chk("retrig_byte", p_byte1, 8'hC3);

        // New start written in the DONE clock is accepted
        xfer(8'h5A, XFER_CYCLES + 1, 16'hFF02, 8'h81, 0, 16'h0000, 8'h00, 24);
        chk("done_start_pulses", p_cnt, 2);
        chk("done_start_t1", p_first, XFER_CYCLES + 1);
        chk("done_start_t2", p_second, 2 * (XFER_CYCLES + 1));
        chk("done_start_b1", p_byte1, 8'h5A);
        chk("done_start_b2", p_byte2, 8'hFF);

        // IF write in the DONE clock merges with the serial request
        cyc(16'hFF0F, 8'h00, 1'b1);
        xfer(8'h11, XFER_CYCLES + 1, 16'hFF0F, 8'h01, 0, 16'h0000, 8'h00, 12);
        chk("if_merge_pulses", p_cnt, 1);
        rd(16'hFF0F, 8'hE9, "if_merge");

        // DIV: cleared at edge W, read at W+256, W+257, W+1000
        cyc(16'hFF04, 8'h00, 1'b1);
        for (int m = 1; m <= 255; m++) cyc(16'h0000, 8'h00, 1'b0);
        rd(16'hFF04, 8'((255 >> DIV_SHIFT) & 8'hFF), "div_256");
        rd(16'hFF04, 8'((256 >> DIV_SHIFT) & 8'hFF), "div_257");
        for (int m = 258; m <= 999; m++) cyc(16'h0000, 8'h00, 1'b0);
        rd(16'hFF04, 8'((999 >> DIV_SHIFT) & 8'hFF), "div_1000");
        cyc(16'hFF04, 8'h77, 1'b1);
        rd(16'hFF04, 8'h00, "div_clear");

        // Asynchronous reset in the middle of a transfer
        cyc(16'hFF0F, 8'h1F, 1'b1);
        cyc(16'hFF01, 8'h66, 1'b1);
        cyc(16'hFF02, 8'h81, 1'b1);
        for (int k = 0; k < 4; k++) cyc(16'h0000, 8'h00, 1'b0);
        chk("pre_rst_read", mem_data_read, 8'hA5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_read", mem_data_read, 8'hFF);
        chk("arst_if", irq_if, 5'h00);
        chk("arst_valid", serial_valid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        idle_pulses = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(16'h0000, 8'h00, 1'b0);
            if (serial_valid) idle_pulses++;
        end
        chk("arst_no_pulse", idle_pulses, 0);
        rd(16'hFF02, 8'h7E, "arst_sc");
        rd(16'hFF0F, 8'hE0, "arst_ifreg");
        rd(16'hFF01, 8'h00, "arst_sb");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
